uart_block_bridge: RTL
======================

Name: uart_block_bridge

Overview:
- Sits between the 128-bit UART transceiver and the block-processing core.
- RX side: buffers each completed 128-bit frame (rx_data qualified by the one-cycle rx_done pulse) in a small FIFO and presents it to the core over a valid/ready handshake.
- TX side: accepts one 128-bit result from the core, issues tx_wr, and holds tx_data stable until tx_done. The transceiver re-reads tx_data for every octet, so tx_data must not change mid-frame.

Parameters:
- ADDR_W, 2, log2 of RX FIFO depth (depth = 2**ADDR_W frames).
- TX_TIMEOUT, 0, cycles to wait for tx_done before abort; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- rx_data  in  128  frame from the transceiver; valid only while rx_done=1.
- rx_done  in  1  one-cycle frame-complete strobe from the transceiver.
- blk_in_data  out  128  head-of-FIFO frame to the core.
- blk_in_valid  out  1  FIFO not empty.
- blk_in_ready  in  1  core accepts blk_in_data.
- blk_out_data  in  128  result from the core.
- blk_out_valid  in  1  result valid.
- blk_out_ready  out  1  bridge can accept a result.
- tx_data  out  128  frame to the transceiver.
- tx_wr  out  1  one-cycle transmit start strobe.
- tx_done  in  1  one-cycle transmit-complete strobe.
- rx_level  out  ADDR_W+1  frames currently held in the FIFO.
- rx_overflow  out  1  sticky: a frame was dropped.
- tx_timeout  out  1  sticky: the watchdog fired.
- flag_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values: blk_in_valid=0, rx_level=0, rx_overflow=0, tx_timeout=0, blk_out_ready=1 (state TX_IDLE), tx_wr=0, tx_data=0. FIFO pointers are zeroed. FIFO storage is not reset.
- RX FIFO:
  - Synchronous circular buffer; read and write pointers are ADDR_W bits and wrap naturally.
  - Output is first-word-fall-through: blk_in_data = mem[rd_ptr]; blk_in_valid = (rx_level != 0).
  - Push when rx_done=1. Pop when blk_in_valid & blk_in_ready.
  - Push and pop may occur in the same cycle; rx_level is then unchanged.
  - Full (rx_level == 2**ADDR_W):
    - rx_done with a same-cycle pop: push accepted.
    - rx_done without a pop: frame dropped, rx_overflow set next cycle, FIFO contents unchanged.
  - Empty: blk_in_ready is ignored and no pop occurs.
  - Latency: a frame pushed at edge N is visible with blk_in_valid=1 after edge N (same data path, no extra stage).
- TX FSM with states TX_IDLE, TX_WR, TX_BUSY:
  - TX_IDLE:
    - blk_out_ready=1.
    - On blk_out_valid: capture tx_data <= blk_out_data, go to TX_WR.
  - TX_WR:
    - blk_out_ready=0, tx_wr=1 for exactly this one cycle.
    - Load the watchdog counter with TX_TIMEOUT.
    - Go to TX_BUSY.
    - tx_done in this state is ignored.
  - TX_BUSY:
    - blk_out_ready=0.
    - On tx_done go to TX_IDLE.
    - Otherwise, if TX_TIMEOUT != 0, decrement the counter (32-bit). When it reaches 1 without tx_done, set tx_timeout and go to TX_IDLE.
    - tx_done takes priority over timeout in the same cycle.
  - tx_data holds from the capture edge until the next capture; it never changes in TX_WR or TX_BUSY.
  - Result-to-tx_wr latency: 1 cycle.
  - Earliest next acceptance: the cycle after tx_done.
- Sticky flags:
  - Cleared by flag_clr or sys_rst.
  - A set event in the same cycle as flag_clr wins (flag reads 1).
- Reset mid-operation:
  - The FIFO is emptied and the FSM returns to TX_IDLE.
  - An in-flight transceiver frame is not aborted by this block. Its later tx_done arrives in TX_IDLE and is ignored.
- RX and TX paths are independent; neither stalls the other.

Test Plan:
1. Single loop: rx_done with rx_data=128'h000102..0F.
   - Next cycle: blk_in_valid=1, blk_in_data matches, rx_level=1.
   - Assert blk_in_ready: rx_level=0.
2. Fill and overflow (ADDR_W=2): 5 rx_done pulses with values 1..5, blk_in_ready=0.
   - rx_level=4, rx_overflow=1.
   - Draining returns 1,2,3,4 in order.
   - flag_clr clears rx_overflow.
3. Full with simultaneous push/pop: FIFO full, rx_done=1 and blk_in_ready=1 in the same cycle.
   - rx_level stays 4, rx_overflow stays 0.
   - Order preserved: the new frame comes out last.
4. TX handshake: blk_out_valid with data=128'hDEADBEEF..., accepted at edge N.
   - tx_wr=1 only in cycle N+1; blk_out_ready=0 until tx_done.
   - Change blk_out_data meanwhile: tx_data is unchanged.
   - tx_done: blk_out_ready=1 the following cycle.
5. Watchdog: TX_TIMEOUT=100, tx_done never arrives.
   - tx_timeout=1 and state TX_IDLE 100 cycles after TX_WR.
   - Repeat with tx_done on the final cycle: tx_timeout stays 0.
6. Reset mid-operation: FIFO holding 3 frames and FSM in TX_BUSY, then sys_rst for 1 cycle.
   - rx_level=0, blk_in_valid=0, blk_out_ready=1.
   - A late tx_done causes no state change.

Source files
------------

// File: rtl/uart_block_bridge.sv
// Bridge between the 128-bit UART transceiver and the block core: an RX frame
// FIFO with first-word-fall-through output and a single-result TX handshake FSM.
module uart_block_bridge #(
  parameter int          ADDR_W     = 2,
  parameter int unsigned TX_TIMEOUT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [127:0]      rx_data,
  input  logic              rx_done,
  output logic [127:0]      blk_in_data,
  output logic              blk_in_valid,
  input  logic              blk_in_ready,
  input  logic [127:0]      blk_out_data,
  input  logic              blk_out_valid,
  output logic              blk_out_ready,
  output logic [127:0]      tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic [ADDR_W:0]   rx_level,
  output logic              rx_overflow,
  output logic              tx_timeout,
  input  logic              flag_clr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {TX_IDLE, TX_WR, TX_BUSY} tx_state_e;

  logic [127:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop, drop;
  logic              rx_overflow_q, tx_timeout_q;

  tx_state_e         state_q, state_d;
  logic [127:0]      tx_data_q, tx_data_d;
  logic [31:0]       wd_cnt_q, wd_cnt_d;
  logic              wd_fire;

  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (ADDR_W+1)'(DEPTH));
  assign pop        = !fifo_empty && blk_in_ready;
  assign push       = rx_done && (!fifo_full || pop);
  assign drop       = rx_done && fifo_full && !pop;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign blk_in_data  = mem_q[rd_ptr_q];
  assign blk_in_valid = !fifo_empty;
  assign rx_level     = level_q;

  // A set event in the same cycle as flag_clr leaves the flag at 1.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_overflow_q <= 1'b0;
      tx_timeout_q  <= 1'b0;
    end else begin
      rx_overflow_q <= drop    || (rx_overflow_q && !flag_clr);
      tx_timeout_q  <= wd_fire || (tx_timeout_q  && !flag_clr);
    end
  end

  assign rx_overflow = rx_overflow_q;
  assign tx_timeout  = tx_timeout_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  // tx_data only loads in TX_IDLE so it stays frozen for the whole transmission.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    wd_cnt_d  = wd_cnt_q;
    wd_fire   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (blk_out_valid) begin
          tx_data_d = blk_out_data;
          state_d   = TX_WR;
        end
      end
      TX_WR: begin
        wd_cnt_d = 32'(TX_TIMEOUT);
        state_d  = TX_BUSY;
      end
      TX_BUSY: begin
        if (tx_done) begin
          state_d = TX_IDLE;
        end else if (TX_TIMEOUT != 0) begin
          if (wd_cnt_q == 32'd1) begin
            wd_fire = 1'b1;
            state_d = TX_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q - 32'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    blk_out_ready = (state_q == TX_IDLE);
    tx_wr         = (state_q == TX_WR);
  end

  assign tx_data = tx_data_q;

endmodule
